vjtag_cmd_sequencer: RTL

Command sequencer behind the virtual-JTAG byte interface, running in the tck domain.
- Parses bytes written by the PC (DR1 updates) into WRITE / READ / STATUS commands.
- Drives a single-master 8-bit register bus with a req/ack handshake.
- Queues read results in a response FIFO, which the PC drains one byte per DR2 capture.
- Turns the single-byte mailbox into an addressed, multi-byte register access channel.

---
 rtl/vjtag_cmd_pkg.sv | 41 ++++
 rtl/vjtag_resp_fifo.sv | 50 +++++
 rtl/vjtag_cmd_sequencer.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/vjtag_cmd_pkg.sv
// Shared opcodes, FSM encoding and status-byte layout for the virtual-JTAG command sequencer.
// Types and constants only; no timing or flow control lives here.
package vjtag_cmd_pkg;
  localparam int ADDR_W = 6;

  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  localparam logic [7:0] TIMEOUT_DATA = 8'hFF;

  localparam int ST_BIT_BUSY  = 7;
  localparam int ST_BIT_FULL  = 6;
  localparam int ST_BIT_EMPTY = 5;
  localparam int ST_BIT_TMO   = 4;
  localparam int ST_BIT_OVR   = 3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET_CNT,
    S_WR_WAIT,
    S_WR_BUS,
    S_RD_WAIT_SPACE,
    S_RD_BUS,
    S_ST_PUSH
  } state_t;

  function automatic logic [7:0] status_byte(input logic busy, input logic full,
                                             input logic empty, input logic tmo,
                                             input logic ovr);
    logic [7:0] b;
    b               = 8'h00;
    b[ST_BIT_BUSY]  = busy;
    b[ST_BIT_FULL]  = full;
    b[ST_BIT_EMPTY] = empty;
    b[ST_BIT_TMO]   = tmo;
    b[ST_BIT_OVR]   = ovr;
    return b;
  endfunction
endpackage

// File: rtl/vjtag_resp_fifo.sv
// Single-clock response FIFO: push/pop take effect at the clock edge, head is combinational.
// Push is refused when full unless a pop frees a slot that cycle; pop when empty is ignored.
module vjtag_resp_fifo #(
  parameter int         DEPTH     = 16,
  parameter logic [7:0] EMPTY_VAL = 8'h00
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_push,
  input  logic [7:0] i_push_dat,
  input  logic       i_pop,
  output logic       o_full,
  output logic       o_empty,
  output logic [7:0] o_head
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == (PTR_W+1)'(DEPTH));
  assign o_head  = o_empty ? EMPTY_VAL : r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);

  always_ff @(posedge i_clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_push_dat;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/vjtag_cmd_sequencer.sv
// Parses PC bytes into WRITE/READ/STATUS commands driving an 8-bit req/ack register bus.
// reg_req rises the edge after its trigger; reads stall until the response FIFO has space.
module vjtag_cmd_sequencer
  import vjtag_cmd_pkg::*;
#(
  parameter int         RESP_DEPTH     = 16,
  parameter int         TIMEOUT_CYCLES = 64,
  parameter logic [7:0] EMPTY_BYTE     = 8'h00
) (
  input  logic              i_tck,
  input  logic              i_aclr,
  input  logic [7:0]        i_rx_byte,
  input  logic              i_rx_valid,
  input  logic              i_tx_pop,
  output logic [7:0]        o_tx_byte,
  output logic              o_reg_req,
  output logic              o_reg_we,
  output logic [ADDR_W-1:0] o_reg_addr,
  output logic [7:0]        o_reg_wdata,
  input  logic              i_reg_ack,
  input  logic [7:0]        i_reg_rdata,
  output logic              o_busy
);
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  state_t            r_state;
  logic              r_is_rd;
  logic [ADDR_W-1:0] r_addr;
  logic [7:0]        r_remaining;
  logic [7:0]        r_wdata;
  logic              r_req;
  logic              r_we;
  logic [TMO_W-1:0]  r_tmo_cnt;
  logic              r_timeout_err;
  logic              r_overrun_err;

  logic              w_full;
  logic              w_empty;
  logic              w_push;
  logic [7:0]        w_push_dat;
  logic              w_tmo_hit;
  logic              w_access_done;

  assign o_reg_req     = r_req;
  assign o_reg_we      = r_we;
  assign o_reg_addr    = r_addr;
  assign o_reg_wdata   = r_wdata;
  assign o_busy        = (r_state != S_IDLE);
  assign w_tmo_hit     = (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));
  assign w_access_done = i_reg_ack || w_tmo_hit;

  always_comb begin
    w_push     = 1'b0;
    w_push_dat = TIMEOUT_DATA;
    if (r_state == S_RD_BUS && w_access_done) begin
      w_push     = 1'b1;
      w_push_dat = i_reg_ack ? i_reg_rdata : TIMEOUT_DATA;
    end else if (r_state == S_ST_PUSH && !w_full) begin
      w_push     = 1'b1;
      w_push_dat = status_byte(o_busy, w_full, w_empty, r_timeout_err, r_overrun_err);
    end
  end

  always_ff @(posedge i_tck) begin
    if (i_aclr) begin
      r_state       <= S_IDLE;
      r_is_rd       <= 1'b0;
      r_addr        <= '0;
      r_remaining   <= '0;
      r_wdata       <= '0;
      r_req         <= 1'b0;
      r_we          <= 1'b0;
      r_tmo_cnt     <= '0;
      r_timeout_err <= 1'b0;
      r_overrun_err <= 1'b0;
    end else begin
      // Bytes arriving while a bus access or push is pending are discarded.
      if (i_rx_valid && (r_state inside {S_WR_BUS, S_RD_WAIT_SPACE, S_RD_BUS, S_ST_PUSH}))
        r_overrun_err <= 1'b1;
      case (r_state)
        S_IDLE: begin
          if (i_rx_valid) begin
            case (i_rx_byte[7:6])
              OP_WRITE, OP_READ: begin
                r_addr  <= i_rx_byte[ADDR_W-1:0];
                r_is_rd <= (i_rx_byte[7:6] == OP_READ);
                r_state <= S_GET_CNT;
              end
              OP_STATUS: r_state <= S_ST_PUSH;
              default:   r_state <= S_IDLE;
            endcase
          end
        end
        S_GET_CNT: begin
          if (i_rx_valid) begin
            r_remaining <= i_rx_byte;
            r_state     <= r_is_rd ? S_RD_WAIT_SPACE : S_WR_WAIT;
          end
        end
        S_WR_WAIT: begin
          if (i_rx_valid) begin
            r_wdata   <= i_rx_byte;
            r_req     <= 1'b1;
            r_we      <= 1'b1;
            r_tmo_cnt <= '0;
            r_state   <= S_WR_BUS;
          end
        end
        S_RD_WAIT_SPACE: begin
          if (!w_full) begin
            r_req     <= 1'b1;
            r_we      <= 1'b0;
            r_tmo_cnt <= '0;
            r_state   <= S_RD_BUS;
          end
        end
        S_WR_BUS, S_RD_BUS: begin
          if (w_access_done) begin
            r_req  <= 1'b0;
            r_addr <= r_addr + 1'b1;
            if (!i_reg_ack) r_timeout_err <= 1'b1;
            if (r_remaining == '0) begin
              r_state <= S_IDLE;
            end else begin
              r_remaining <= r_remaining - 1'b1;
              r_state     <= r_is_rd ? S_RD_WAIT_SPACE : S_WR_WAIT;
            end
          end else begin
            r_tmo_cnt <= r_tmo_cnt + 1'b1;
          end
        end
        S_ST_PUSH: begin
          if (!w_full) begin
            r_timeout_err <= 1'b0;
            r_overrun_err <= i_rx_valid;
            r_state       <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  vjtag_resp_fifo #(
    .DEPTH     (RESP_DEPTH),
    .EMPTY_VAL (EMPTY_BYTE)
  ) u_resp_fifo (
    .i_clk      (i_tck),
    .i_rst      (i_aclr),
    .i_push     (w_push),
    .i_push_dat (w_push_dat),
    .i_pop      (i_tx_pop),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_head     (o_tx_byte)
  );
endmodule
